blink_meter: RTL and testbench



---
 rtl/blink_pkg.sv | 13 +
 rtl/blink_meter_if.sv | 22 ++
 rtl/blink_sync_edge.sv | 81 ++++++++
 rtl/blink_meter.sv | 141 ++++++++++++++
 tb/tb_blink_meter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/blink_pkg.sv
// Shared types and default sizing for the blink_meter block.
package blink_pkg;

  localparam int unsigned CNT_W_DEF   = 32'd32;
  localparam int unsigned TIMEOUT_DEF = 32'd1000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STALLED = 2'd2
  } meter_state_t;

endpackage

// File: rtl/blink_meter_if.sv
// Measurement bus of blink_meter: monitored input, clear, and measurement results.
interface blink_meter_if #(
  parameter int unsigned CNT_W = blink_pkg::CNT_W_DEF
);
  logic             sig_in;
  logic             clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             stalled;
  logic [CNT_W-1:0] edge_count;

  modport master (
    output sig_in, clr,
    input  period, high_time, meas_valid, stalled, edge_count
  );

  modport slave (
    input  sig_in, clr,
    output period, high_time, meas_valid, stalled, edge_count
  );
endinterface

// File: rtl/blink_sync_edge.sv
// Synchronizer, optional deglitch filter (BLINK_METER_DEGLITCH_EN) and rise/fall pulse generator.
module blink_sync_edge #(
  parameter int unsigned SYNC_STAGES = 32'd2,
  parameter int unsigned FILT_LEN    = 32'd4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_s;
  logic                   level_s;
  logic                   prev_q;

  // synchronizer shift chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
    end
  end

  assign synced_s = sync_q[SYNC_STAGES-1];

`ifdef BLINK_METER_DEGLITCH_EN
  localparam int unsigned FCW = $clog2(FILT_LEN + 32'd1);

  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  // level follows synced only after FILT_LEN consecutive differing cycles
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (synced_s != filt_q) begin
      if (fcnt_q == FCW'(FILT_LEN - 32'd1)) begin
        filt_d = synced_s;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end else begin
      fcnt_d = '0;
    end
  end

  // filter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level_s = filt_q;
`else
  logic unused_filt_len_s;
  assign unused_filt_len_s = (FILT_LEN > 32'd0);
  assign level_s           = synced_s;
`endif

  // history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_s;
    end
  end

  assign rise_o = level_s & ~prev_q;
  assign fall_o = ~level_s & prev_q;

endmodule

// File: rtl/blink_meter.sv
// Period / high-time / edge-count meter with stall detection for a toggling input.
// Optional deglitch filter enabled by defining BLINK_METER_DEGLITCH_EN.
module blink_meter
  import blink_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 32'd2,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned FILT_LEN    = 32'd4
) (
  input  logic          clk,
  input  logic          rst_n,
  blink_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             mv_q, mv_d;
  logic             stalled_q, stalled_d;
  logic             rise_s, fall_s;

  blink_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (bus.sig_in),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // next-state and measurement logic; clr overrides every edge
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    hi_lat_d  = hi_lat_q;
    period_d  = period_q;
    high_d    = high_q;
    edge_d    = edge_q;
    mv_d      = 1'b0;
    stalled_d = stalled_q;
    if (bus.clr) begin
      state_d   = IDLE;
      cyc_d     = '0;
      hi_lat_d  = '0;
      period_d  = '0;
      high_d    = '0;
      edge_d    = '0;
      stalled_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_s) begin
            state_d = RUN;
            cyc_d   = ONE_C;
            edge_d  = edge_q + ONE_C;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (cyc_q != CNT_MAX) begin
            cyc_d = cyc_q + ONE_C;
          end else begin
            cyc_d = cyc_q;
          end
          if (fall_s) begin
            hi_lat_d = cyc_q;
          end else begin
            hi_lat_d = hi_lat_q;
          end
          // a rise coinciding with the timeout is a normal measurement
          if (rise_s) begin
            period_d = cyc_q;
            high_d   = hi_lat_q;
            mv_d     = 1'b1;
            cyc_d    = ONE_C;
            edge_d   = edge_q + ONE_C;
          end else if (cyc_q == TIMEOUT_C) begin
            state_d   = STALLED;
            stalled_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        STALLED: begin
          if (rise_s) begin
            state_d   = RUN;
            stalled_d = 1'b0;
            cyc_d     = ONE_C;
            edge_d    = edge_q + ONE_C;
          end else begin
            stalled_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // state and measurement registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      hi_lat_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      edge_q    <= '0;
      mv_q      <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      hi_lat_q  <= hi_lat_d;
      period_q  <= period_d;
      high_q    <= high_d;
      edge_q    <= edge_d;
      mv_q      <= mv_d;
      stalled_q <= stalled_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.edge_count = edge_q;
  assign bus.meas_valid = mv_q;
  assign bus.stalled    = stalled_q;

endmodule

// File: tb/tb_blink_meter.sv
// Directed self-checking bench for blink_meter (TIMEOUT reduced to 64).
module tb_blink_meter;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mv_cnt   = 0;
  logic [31:0] last_period = 32'd0;
  logic [31:0] last_high   = 32'd0;
  int   exp_ec;
  int   exp_mv;

  blink_meter_if #(.CNT_W(32'd32)) bus_if ();

  blink_meter #(
    .CNT_W       (32'd32),
    .SYNC_STAGES (32'd2),
    .TIMEOUT     (32'd64),
    .FILT_LEN    (32'd4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // capture every meas_valid pulse away from the active edge
  always @(negedge clk) begin
    if (bus_if.meas_valid) begin
      mv_cnt      <= mv_cnt + 1;
      last_period <= bus_if.period;
      last_high   <= bus_if.high_time;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wave(input int hi, input int lo);
    bus_if.sig_in = 1'b1;
    tick(hi);
    bus_if.sig_in = 1'b0;
    tick(lo);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_period"}, bus_if.period, 32'd0);
    check_eq({tag, "_high"}, bus_if.high_time, 32'd0);
    check_eq({tag, "_ec"}, bus_if.edge_count, 32'd0);
    check_eq({tag, "_mv"}, {31'd0, bus_if.meas_valid}, 32'd0);
    check_eq({tag, "_stalled"}, {31'd0, bus_if.stalled}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus_if.sig_in = 1'b0;
    bus_if.clr    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_if.sig_in = ~bus_if.sig_in;
      tick(1);
    end
    check_outputs_zero("rst");
    rst_n = 1'b1;
    tick(10);
    check_outputs_zero("post_rst");

    // 5/5 square wave: first rise arms, second measures
    wave(5, 5);
    check_eq("arm_ec", bus_if.edge_count, 32'd1);
    check_eq("arm_mv", mv_cnt, 32'd0);
    wave(5, 5);
    check_eq("sq_mv", mv_cnt, 32'd1);
    check_eq("sq_period", last_period, 32'd10);
    check_eq("sq_high", last_high, 32'd5);
    check_eq("sq_ec", bus_if.edge_count, 32'd2);
    check_eq("sq_hold_period", bus_if.period, 32'd10);

    // duty 3/7: second measurement reports the 3-cycle high time
    wave(3, 7);
    wave(3, 7);
    check_eq("duty_mv", mv_cnt, 32'd3);
    check_eq("duty_period", last_period, 32'd10);
    check_eq("duty_high", last_high, 32'd3);
    check_eq("duty_ec", bus_if.edge_count, 32'd4);

    // stall exactly 64 cycles after the rise is captured (3 ticks after setting)
    bus_if.sig_in = 1'b1;
    tick(5);
    bus_if.sig_in = 1'b0;
    tick(61);
    check_eq("stall_early", {31'd0, bus_if.stalled}, 32'd0);
    tick(1);
    check_eq("stall_set", {31'd0, bus_if.stalled}, 32'd1);
    check_eq("stall_mv", mv_cnt, 32'd4);
    tick(20);
    check_eq("stall_hold", {31'd0, bus_if.stalled}, 32'd1);

    // recovery rise clears stalled without a measurement
    bus_if.sig_in = 1'b1;
    tick(5);
    check_eq("recov_stalled", {31'd0, bus_if.stalled}, 32'd0);
    check_eq("recov_mv", mv_cnt, 32'd4);
    check_eq("recov_ec", bus_if.edge_count, 32'd6);
    bus_if.sig_in = 1'b0;
    tick(5);
    bus_if.sig_in = 1'b1;
    tick(5);
    check_eq("recov2_mv", mv_cnt, 32'd5);
    check_eq("recov2_period", last_period, 32'd10);
    check_eq("recov2_high", last_high, 32'd5);

    // clr mid-RUN
    bus_if.clr = 1'b1;
    tick(1);
    bus_if.clr = 1'b0;
    check_outputs_zero("clr");
    bus_if.sig_in = 1'b0;
    tick(5);
    bus_if.sig_in = 1'b1;
    tick(5);
    check_eq("clr_arm_ec", bus_if.edge_count, 32'd1);
    check_eq("clr_arm_mv", mv_cnt, 32'd5);
    bus_if.sig_in = 1'b0;
    tick(5);
    bus_if.sig_in = 1'b1;
    tick(5);
    check_eq("clr_meas_mv", mv_cnt, 32'd6);
    check_eq("clr_meas_period", last_period, 32'd10);
    check_eq("clr_meas_high", last_high, 32'd5);
    check_eq("clr_meas_ec", bus_if.edge_count, 32'd2);

    // 2-cycle glitch on a low line
    exp_ec = 2;
    exp_mv = 6;
    bus_if.sig_in = 1'b0;
    tick(10);
    bus_if.sig_in = 1'b1;
    tick(2);
    bus_if.sig_in = 1'b0;
    tick(10);
`ifdef BLINK_METER_DEGLITCH_EN
    check_eq("glitch_ec", bus_if.edge_count, 32'(exp_ec));
`else
    exp_ec = exp_ec + 1;
    exp_mv = exp_mv + 1;
    check_eq("glitch_ec", bus_if.edge_count, 32'(exp_ec));
    check_eq("glitch_period", last_period, 32'd15);
`endif
    check_eq("glitch_mv", mv_cnt, 32'(exp_mv));

    // rise landing exactly on the timeout cycle wins over the stall
    bus_if.sig_in = 1'b1;
    tick(5);
    bus_if.sig_in = 1'b0;
    tick(59);
    bus_if.sig_in = 1'b1;
    tick(5);
    exp_mv = exp_mv + 2;
    exp_ec = exp_ec + 2;
    check_eq("tmo_edge_stalled", {31'd0, bus_if.stalled}, 32'd0);
    check_eq("tmo_edge_period", last_period, 32'd64);
    check_eq("tmo_edge_high", last_high, 32'd5);
    check_eq("tmo_edge_mv", mv_cnt, 32'(exp_mv));
    check_eq("tmo_edge_ec", bus_if.edge_count, 32'(exp_ec));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
